hwag_coil_bank: RTL and testbench

Parametrised multi-channel ignition output stage driven by the angle generator's `acnt2` angle count and `hwag_start` sync status. Each channel holds a programmable set (dwell start) and reset (spark) angle, double-buffered and applied at the angle wrap. Outputs are switched on window-crossing, so angle jumps (resync, `sload`) never lose an event. A per-channel maximum-dwell watchdog forces the coil off and latches a fault.

---
 rtl/hwag_coil_bank.sv | 167 ++++++++++++++++
 tb/tb_hwag_coil_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_coil_bank.sv
// rtl/hwag_coil_bank.sv - multi-channel ignition coil output stage driven by angle window crossings
module hwag_coil_bank #(
  parameter int                     CHANNELS    = 4,
  parameter int                     ANGLE_WIDTH = 24,
  parameter logic [ANGLE_WIDTH-1:0] MAXACR      = 24'd3839,
  parameter int                     DWELL_WIDTH = 24,
  parameter bit                     ACTIVE_HIGH = 1'b1,
  localparam int                    CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   angle_stb,
  input  logic                   sync,
  input  logic                   wr_en,
  input  logic [CH_W-1:0]        wr_ch,
  input  logic                   wr_sel,
  input  logic [ANGLE_WIDTH-1:0] wr_data,
  input  logic [CHANNELS-1:0]    ch_ena,
  input  logic [DWELL_WIDTH-1:0] max_dwell,
  input  logic                   fault_clr,
  output logic [CHANNELS-1:0]    coil_out,
  output logic [CHANNELS-1:0]    pending,
  output logic [CHANNELS-1:0]    dwell_fault,
  output logic                   wr_err
);

  localparam int             AW     = ANGLE_WIDTH;
  localparam logic [CH_W:0]  CH_LIM = (CH_W+1)'(CHANNELS);

  // State registers
  logic [AW-1:0]          prev_q, prev_d;
  logic                   sync_d_q;
  logic                   wr_err_q, wr_err_d;
  logic [CHANNELS-1:0]    on_q, on_d;
  logic [CHANNELS-1:0]    pending_q, pending_d;
  logic [CHANNELS-1:0]    fault_q, fault_d;
  logic [AW-1:0]          set_sh_q  [CHANNELS];
  logic [AW-1:0]          set_sh_d  [CHANNELS];
  logic [AW-1:0]          rst_sh_q  [CHANNELS];
  logic [AW-1:0]          rst_sh_d  [CHANNELS];
  logic [AW-1:0]          set_act_q [CHANNELS];
  logic [AW-1:0]          set_act_d [CHANNELS];
  logic [AW-1:0]          rst_act_q [CHANNELS];
  logic [AW-1:0]          rst_act_d [CHANNELS];
  logic [DWELL_WIDTH-1:0] dwell_q   [CHANNELS];
  logic [DWELL_WIDTH-1:0] dwell_d   [CHANNELS];

  // Per-cycle decode
  logic                sync_rise, eval, wrap, wr_ok;
  logic [CHANNELS-1:0] x_set, x_rst, trip, on_nxt;

  // True when point p lies in the half-open window (prv, cur], modulo the angle wrap
  function automatic logic crossed(input logic [AW-1:0] p, input logic [AW-1:0] prv,
                                   input logic [AW-1:0] cur);
    if (cur > prv)      crossed = (p > prv) && (p <= cur);
    else if (cur < prv) crossed = (p > prv) || (p <= cur);
    else                crossed = 1'b0;
  endfunction

  // Angular distance from point p back to cur; a smaller value means p was passed later
  function automatic logic [AW:0] lateness(input logic [AW-1:0] p, input logic [AW-1:0] cur);
    if (cur >= p) lateness = {1'b0, cur} - {1'b0, p};
    else          lateness = {1'b0, cur} + {1'b0, MAXACR} + (AW+1)'(1) - {1'b0, p};
  endfunction

  // Strobe qualification and write validation
  always_comb begin
    sync_rise = sync && !sync_d_q;
    eval      = angle_stb && sync && sync_d_q;
    wrap      = eval && (angle < prev_q);
    wr_ok     = ({1'b0, wr_ch} < CH_LIM) && (wr_data <= MAXACR);
    wr_err_d  = wr_en && !wr_ok;
    prev_d    = prev_q;
    if (angle_stb || sync_rise) prev_d = angle;
  end

  // Per-channel point buffering, event resolution and dwell watchdog
  always_comb begin
    pending_d = pending_q;
    on_d      = on_q;
    fault_d   = fault_q;
    x_set     = '0;
    x_rst     = '0;
    trip      = '0;
    on_nxt    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      set_sh_d[i]  = set_sh_q[i];
      rst_sh_d[i]  = rst_sh_q[i];
      set_act_d[i] = set_act_q[i];
      rst_act_d[i] = rst_act_q[i];
      dwell_d[i]   = dwell_q[i];

      // Wrap applies the shadow; a write landing in the same cycle waits for the next wrap
      if (wrap) begin
        set_act_d[i] = set_sh_q[i];
        rst_act_d[i] = rst_sh_q[i];
        pending_d[i] = 1'b0;
      end
      if (wr_en && wr_ok && (wr_ch == CH_W'(i))) begin
        if (!wr_sel) set_sh_d[i] = wr_data;
        else         rst_sh_d[i] = wr_data;
        if (!sync) begin
          if (!wr_sel) set_act_d[i] = wr_data;
          else         rst_act_d[i] = wr_data;
        end else begin
          pending_d[i] = 1'b1;
        end
      end

      // Events use the points that were active before this strobe
      x_set[i]  = eval && crossed(set_act_q[i], prev_q, angle);
      x_rst[i]  = eval && crossed(rst_act_q[i], prev_q, angle);
      on_nxt[i] = on_q[i];
      if (x_set[i] && !x_rst[i])      on_nxt[i] = 1'b1;
      else if (x_rst[i] && !x_set[i]) on_nxt[i] = 1'b0;
      else if (x_set[i] && x_rst[i])
        on_nxt[i] = lateness(set_act_q[i], angle) < lateness(rst_act_q[i], angle);

      trip[i] = on_q[i] && (max_dwell != '0) && (dwell_q[i] == max_dwell);
      if (trip[i] || fault_q[i]) on_nxt[i] = 1'b0;
      if (!sync || !ch_ena[i])   on_nxt[i] = 1'b0;

      on_d[i]    = on_nxt[i];
      dwell_d[i] = (on_q[i] && on_nxt[i]) ? dwell_q[i] + DWELL_WIDTH'(1) : '0;
      if (trip[i])        fault_d[i] = 1'b1;
      else if (fault_clr) fault_d[i] = 1'b0;
    end
  end

  // Register update with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      sync_d_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      on_q      <= '0;
      pending_q <= '0;
      fault_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        set_sh_q[i]  <= '0;
        rst_sh_q[i]  <= '0;
        set_act_q[i] <= '0;
        rst_act_q[i] <= '0;
        dwell_q[i]   <= '0;
      end
    end else begin
      prev_q    <= prev_d;
      sync_d_q  <= sync;
      wr_err_q  <= wr_err_d;
      on_q      <= on_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
      set_sh_q  <= set_sh_d;
      rst_sh_q  <= rst_sh_d;
      set_act_q <= set_act_d;
      rst_act_q <= rst_act_d;
      dwell_q   <= dwell_d;
    end
  end

  assign coil_out    = ACTIVE_HIGH ? on_q : ~on_q;
  assign pending     = pending_q;
  assign dwell_fault = fault_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_hwag_coil_bank.sv
// tb/tb_hwag_coil_bank.sv - self-checking bench for hwag_coil_bank
module tb_hwag_coil_bank;
  localparam int CH = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [23:0]   angle = '0;
  logic          angle_stb = 1'b0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic          wr_sel = 1'b0;
  logic [23:0]   wr_data = '0;
  logic [CH-1:0] ch_ena = '1;
  logic [23:0]   max_dwell = '0;
  logic          fault_clr = 1'b0;
  logic [CH-1:0] coil_out, pending, dwell_fault;
  logic          wr_err;

  int tests_run = 0;
  int fails = 0;

  logic  exp_q[$];
  string name_q[$];

  hwag_coil_bank #(.CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_stb(angle_stb), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
    .ch_ena(ch_ena), .max_dwell(max_dwell), .fault_clr(fault_clr),
    .coil_out(coil_out), .pending(pending), .dwell_fault(dwell_fault), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Strobe an angle; expected coil_out[0] is queued now and checked once the DUT has reacted
  task automatic do_strobe(input logic [23:0] a, input logic exp_on, input string nm);
    logic e;
    string n;
    exp_q.push_back(exp_on);
    name_q.push_back(nm);
    @(negedge clk);
    angle = a;
    angle_stb = 1'b1;
    @(negedge clk);
    angle_stb = 1'b0;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    tests_run++;
    if (coil_out[0] !== e) begin
      fails++;
      $display("FAIL %s angle=%0d coil_out[0]=%b expected=%b", n, a, coil_out[0], e);
    end
  endtask

  task automatic do_write(input logic [CW-1:0] ch, input logic sel, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = ch; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_sync(input logic v);
    @(negedge clk);
    sync = v;
    @(negedge clk);
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_bit("reset_coil0", coil_out[0], 1'b0);
    check_bit("reset_coil2", coil_out[2], 1'b0);
    check_bit("reset_pending", |pending, 1'b0);
    check_bit("reset_fault", |dwell_fault, 1'b0);
    check_bit("reset_wr_err", wr_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    do_write(0, 1'b0, 24'd32);
    check_bit("sweep_pending_set", pending[0], 1'b0);
    do_write(0, 1'b1, 24'd96);
    check_bit("sweep_pending_rst", pending[0], 1'b0);
    angle = 24'd0;
    set_sync(1'b1);
    for (int a = 1; a <= 3840; a++) begin
      int am;
      am = a % 3840;
      do_strobe(24'(am), (am >= 32) && (am < 96), "sweep");
    end
    check_bit("sweep_pending_end", pending[0], 1'b0);
  endtask

  task automatic test_wr_err;
    do_write(0, 1'b0, 24'd3840);
    check_bit("wr_err_range", wr_err, 1'b1);
    check_bit("wr_err_range_pending", pending[0], 1'b0);
    @(negedge clk);
    check_bit("wr_err_one_pulse", wr_err, 1'b0);
    do_write(2'd3, 1'b0, 24'd100);
    check_bit("wr_err_channel", wr_err, 1'b1);
    check_bit("wr_err_channel_pending", |pending, 1'b0);
    do_write(2'd1, 1'b0, 24'd100);
    check_bit("wr_ok_ch1", wr_err, 1'b0);
    check_bit("wr_ok_ch1_pending", pending[1], 1'b1);
    do_strobe(24'd40, 1'b1, "wr_err_active_kept");
  endtask

  task automatic test_jump;
    do_strobe(24'd3839, 1'b0, "jump_pre_off");
    do_strobe(24'd20, 1'b0, "jump_wrap_20");
    do_strobe(24'd100, 1'b0, "jump_both_reset_later");
    set_sync(1'b0);
    do_write(0, 1'b0, 24'd3800);
    do_write(0, 1'b1, 24'd50);
    angle = 24'd90;
    set_sync(1'b1);
    do_strobe(24'd40, 1'b1, "jump_wrap_set_only");
    @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
    check_bit("sync_loss_off", coil_out[0], 1'b0);
  endtask

  task automatic test_pending;
    do_write(0, 1'b0, 24'd32);
    do_write(0, 1'b1, 24'd96);
    angle = 24'd0;
    set_sync(1'b1);
    do_strobe(24'd40, 1'b1, "pend_on_32");
    do_strobe(24'd100, 1'b0, "pend_off_96");
    do_strobe(24'd1000, 1'b0, "pend_idle");
    do_write(0, 1'b0, 24'd200);
    check_bit("pend_set", pending[0], 1'b1);
    do_strobe(24'd3839, 1'b0, "pend_pre_wrap");
    @(negedge clk);
    angle = 24'd0; angle_stb = 1'b1;
    wr_en = 1'b1; wr_ch = 0; wr_sel = 1'b1; wr_data = 24'd2000;
    @(negedge clk);
    angle_stb = 1'b0; wr_en = 1'b0;
    check_bit("pend_write_on_apply", pending[0], 1'b1);
    do_strobe(24'd40, 1'b0, "pend_old_set_gone");
    do_strobe(24'd150, 1'b0, "pend_rst96_still");
    do_strobe(24'd250, 1'b1, "pend_new_set_200");
    do_strobe(24'd3000, 1'b1, "pend_hold");
    do_strobe(24'd3839, 1'b1, "pend_hold_end");
    do_strobe(24'd0, 1'b1, "pend_second_wrap");
    check_bit("pend_cleared", pending[0], 1'b0);
    do_strobe(24'd150, 1'b1, "pend_rst96_gone");
    do_strobe(24'd2100, 1'b0, "pend_both_rst_later");
  endtask

  task automatic test_watchdog;
    int n;
    set_sync(1'b0);
    do_write(0, 1'b0, 24'd32);
    do_write(0, 1'b1, 24'd3000);
    max_dwell = 24'd10;
    angle = 24'd0;
    set_sync(1'b1);
    do_strobe(24'd40, 1'b1, "wd_on");
    n = 1;
    repeat (20) begin
      @(negedge clk);
      if (coil_out[0]) n++;
    end
    tests_run++;
    if (n != 11) begin
      fails++;
      $display("FAIL wd_on_time got=%0d expected=11", n);
    end
    check_bit("wd_fault", dwell_fault[0], 1'b1);
    do_strobe(24'd3839, 1'b0, "wd_off");
    do_strobe(24'd40, 1'b0, "wd_blocked");
    check_bit("wd_fault_sticky", dwell_fault[0], 1'b1);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_bit("wd_fault_clr", dwell_fault[0], 1'b0);
    do_strobe(24'd3839, 1'b0, "wd_pre_wrap");
    do_strobe(24'd40, 1'b1, "wd_on_again");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_bit("areset_coil", coil_out[0], 1'b0);
    check_bit("areset_fault", |dwell_fault, 1'b0);
    check_bit("areset_pending", |pending, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sync = 1'b0;
    angle = 24'd0;
    set_sync(1'b1);
    do_strobe(24'd40, 1'b0, "areset_points_cleared");
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_wr_err();
    test_jump();
    test_pending();
    test_watchdog();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
